// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, latency floor.
package mdu_pkg;

  localparam int MDU_MUL_LAT_MIN = 1;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV_RUN,
    S_DIV_FIX
  } mdu_state_e;

endpackage

// File: rtl/mdu_hilo_if.sv
// Request/response bundle between the execute stage and the HI/LO unit.
interface mdu_hilo_if import mdu_pkg::*; #(parameter int WIDTH = 32);
  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             flush;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, src1, src2, flush,
                  input  busy, stall_req, done, hi, lo);
  modport slave  (input  start, op, src1, src2, flush,
                  output busy, stall_req, done, hi, lo);
endinterface

// File: rtl/mdu_divider.sv
// Restoring radix-2 divider on magnitudes; first quotient bit is resolved on the load edge,
// so magnitudes are final once cnt reaches WIDTH and quo/rem carry the signs combinationally.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             run,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic [WIDTH-1:0] a_mag, b_mag, r_in, q_in, d_in, r_nxt, q_nxt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH:0]   sh, diff;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q, rneg_q;

  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  assign r_in = load ? '0    : rem_q;
  assign q_in = load ? a_mag : quo_q;
  assign d_in = load ? b_mag : dvs_q;

  // Partial remainder is always < divisor, so the W+1 bit borrow is an exact compare
  assign sh    = {r_in, q_in[WIDTH-1]};
  assign diff  = sh - {1'b0, d_in};
  assign r_nxt = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_nxt = {q_in[WIDTH-2:0], ~diff[WIDTH]};

  assign fin = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      if (load || (run && !fin)) begin
        rem_q <= r_nxt;
        quo_q <= q_nxt;
        cnt_q <= load ? CW'(1) : cnt_q + CW'(1);
      end
      if (load) begin
        dvs_q  <= b_mag;
        qneg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_q <= sgn & a[WIDTH-1];
      end
    end
  end

  assign quo = qneg_q ? -quo_q : quo_q;
  assign rem = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO owner with a fixed-latency multiplier pipe and a multi-cycle divider.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU finish in one cycle with HI/LO untouched.
module mdu_hilo import mdu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic      clk,
  input  logic      rstn,
  mdu_hilo_if.slave bus
);
  localparam int LAT = (MUL_LAT < MDU_MUL_LAT_MIN) ? MDU_MUL_LAT_MIN : MUL_LAT;

  mdu_state_e         st, nxt;
  logic               accept, op_mul, op_div, busy, sx, mul_commit, div_done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] ext1, ext2, prod_comb, prod_tail;
  logic [LAT:1]       vld_q;
  logic [LAT:0]       vld_pipe;

  assign op_mul = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
  assign op_div = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
  assign accept = (st == S_IDLE) && bus.start && !bus.flush;
  assign busy   = (st != S_IDLE);

  assign bus.busy      = busy;
  assign bus.stall_req = busy | (bus.start & (op_mul | op_div));
  assign bus.done      = vld_pipe[LAT] | div_done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  // Multiplier: sign-extend to 2W so one unsigned multiply serves both ops
  assign sx        = (bus.op == MDU_MULT);
  assign ext1      = {{WIDTH{sx & bus.src1[WIDTH-1]}}, bus.src1};
  assign ext2      = {{WIDTH{sx & bus.src2[WIDTH-1]}}, bus.src2};
  assign prod_comb = ext1 * ext2;

  // vld_pipe[k] is high in cycle k after accept; HI/LO are the last product stage
  assign vld_pipe   = {vld_q, accept & op_mul};
  assign mul_commit = vld_pipe[LAT-1] & ~bus.flush;

  if (LAT == 1) begin : g_lat1
    assign prod_tail = prod_comb;
  end else begin : g_latn
    logic [LAT-2:0][2*WIDTH-1:0] prod_q;
    always_ff @(posedge clk) begin
      prod_q[0] <= prod_comb;
      for (int i = 1; i < LAT-1; i++) prod_q[i] <= prod_q[i-1];
    end
    assign prod_tail = prod_q[LAT-2];
  end

`ifdef MDU_DIV_EN
  logic             div_zero, div_load, div_fin, div_commit;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign div_zero   = (bus.src2 == '0);
  assign div_load   = accept & op_div & ~div_zero;
  assign div_commit = (st == S_DIV_RUN) & div_fin & ~bus.flush;

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk  (clk),
    .rstn (rstn),
    .load (div_load),
    .run  (st == S_DIV_RUN),
    .sgn  (bus.op == MDU_DIV),
    .a    (bus.src1),
    .b    (bus.src2),
    .fin  (div_fin),
    .quo  (div_quo),
    .rem  (div_rem)
  );
`endif

  always_comb begin
    nxt = st;
    case (st)
      S_IDLE: begin
        if (accept && op_mul) nxt = S_MUL;
`ifdef MDU_DIV_EN
        else if (div_load) nxt = S_DIV_RUN;
`endif
        else if (accept && op_div) nxt = S_DIV_FIX;
      end
      S_MUL:     if (bus.flush || vld_pipe[LAT]) nxt = S_IDLE;
      S_DIV_RUN: begin
        if (bus.flush) nxt = S_IDLE;
`ifdef MDU_DIV_EN
        else if (div_fin) nxt = S_DIV_FIX;
`endif
      end
      S_DIV_FIX: nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= S_IDLE;
      vld_q      <= '0;
      div_done_q <= 1'b0;
    end else begin
      st         <= nxt;
      vld_q      <= vld_pipe[LAT-1:0] & {LAT{~bus.flush}};
      div_done_q <= (st != S_DIV_FIX) && (nxt == S_DIV_FIX);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept && bus.op == MDU_MTHI) hi_q <= bus.src1;
      if (accept && bus.op == MDU_MTLO) lo_q <= bus.src1;
      if (mul_commit) {hi_q, lo_q} <= prod_tail;
`ifdef MDU_DIV_EN
      if (accept && op_div && div_zero) begin
        hi_q <= bus.src1;
        lo_q <= '1;
      end
      if (div_commit) begin
        hi_q <= div_rem;
        lo_q <= div_quo;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: driver pushes expected commits, a negedge monitor checks each done.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 3;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;
  exp_t        sb[$];

  mdu_hilo_if #(.WIDTH(W)) bus();

  mdu_hilo #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Architectural result of one op; lat = cycles from accept to done, 0 = no done pulse
  function automatic void model(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l, output int lat);
    longint      sa, sb2;
    logic [63:0] p;
    lat = 0;
    case (o)
      MDU_MULT: begin
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        {h, l} = sa * sb2;
        lat = MUL_LAT;
      end
      MDU_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        {h, l} = p;
        lat = MUL_LAT;
      end
      MDU_DIV, MDU_DIVU: begin
        lat = 1;
`ifdef MDU_DIV_EN
        if (b == 0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else begin
          lat = W + 1;
          if (o == MDU_DIV) begin
            sa = longint'($signed(a));
            sb2 = longint'($signed(b));
            l = 32'(sa / sb2);
            h = 32'(sa % sb2);
          end else begin
            l = a / b;
            h = a % b;
          end
        end
`endif
      end
      MDU_MTHI: h = a;
      MDU_MTLO: l = a;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.done) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_hi", bus.hi, e.hi);
        check("done_lo", bus.lo, e.lo);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", bus.busy, 0);
  endtask

  // Issue one op; flush_at > 0 raises flush in that cycle after accept
  task automatic run_op(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at);
    logic [31:0] h, l;
    int lat, c0, k;
    h = ref_hi;
    l = ref_lo;
    model(o, a, b, h, l, lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src1  = a;
    bus.src2  = b;
    #1 check("stall_req", bus.stall_req, lat != 0);
    c0 = cyc;
    if (lat != 0 && flush_at == 0) sb.push_back('{c0 + lat, h, l});
    if (flush_at == 0) begin
      ref_hi = h;
      ref_lo = l;
    end
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    while (bus.busy && k <= 200) begin
      if (k == flush_at) bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      k++;
    end
    check("busy_len", k - 1, (flush_at != 0) ? flush_at : lat);
    check("hi", bus.hi, ref_hi);
    check("lo", bus.lo, ref_lo);
  endtask

  initial begin
    mdu_op_e     o;
    logic [31:0] a, b, h, l;
    int          fa, lat, c0;

    bus.start = 1'b0;
    bus.op    = MDU_MULT;
    bus.src1  = '0;
    bus.src2  = '0;
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);

    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 0);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFE);
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
    check("multu_hi", bus.hi, 32'h1);
    check("multu_lo", bus.lo, 32'hFFFF_FFFE);

    run_op(MDU_MTHI, 32'h1234, 32'h0, 0);
    run_op(MDU_MTLO, 32'h5678, 32'h0, 0);
    run_op(MDU_MULT, 32'h1111, 32'h2222, 2);
    check("mul_flush_hi", bus.hi, 32'h1234);
    check("mul_flush_lo", bus.lo, 32'h5678);
`ifdef MDU_DIV_EN
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_flush_hi", bus.hi, 32'h1234);
    check("div_flush_lo", bus.lo, 32'h5678);
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_hi", bus.hi, 32'h0);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    run_op(MDU_DIVU, 32'd5, 32'd0, 0);
    check("divz_hi", bus.hi, 32'd5);
    check("divz_lo", bus.lo, 32'hFFFF_FFFF);
`else
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("nodiv_hi", bus.hi, 32'h1234);
    check("nodiv_lo", bus.lo, 32'h5678);
    run_op(MDU_DIVU, 32'd5, 32'd0, 0);
    check("nodivz_lo", bus.lo, 32'h5678);
`endif

    // MTLO held on start while the multiply is in flight must be ignored
    h = ref_hi;
    l = ref_lo;
    model(MDU_MULT, 32'd7, 32'd9, h, l, lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MDU_MULT;
    bus.src1  = 32'd7;
    bus.src2  = 32'd9;
    c0 = cyc;
    sb.push_back('{c0 + lat, h, l});
    ref_hi = h;
    ref_lo = l;
    @(negedge clk);
    bus.op   = MDU_MTLO;
    bus.src1 = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    @(negedge clk);
    check("mtlo_ignored", bus.lo, 32'd63);
    run_op(MDU_MTLO, 32'hA5A5_A5A5, 32'h0, 0);
    check("mtlo_idle", bus.lo, 32'hA5A5_A5A5);

    for (int i = 0; i < 60; i++) begin
      o  = mdu_op_e'($urandom_range(0, 5));
      a  = rnd_val();
      b  = rnd_val();
      fa = 0;
      if ((o == MDU_MULT || o == MDU_MULTU) && $urandom_range(0, 4) == 0)
        fa = $urandom_range(1, MUL_LAT - 1);
`ifdef MDU_DIV_EN
      if ((o == MDU_DIV || o == MDU_DIVU) && b != 0 && $urandom_range(0, 4) == 0)
        fa = $urandom_range(1, W);
`endif
      run_op(o, a, b, fa);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset mid-multiply: immediate clear, no commit afterwards
    run_op(MDU_MTHI, 32'hDEAD_BEEF, 32'h0, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MDU_MULTU;
    bus.src1  = 32'h3;
    bus.src2  = 32'h5;
    @(negedge clk);
    bus.start = 1'b0;
    #1 rstn = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    @(negedge clk);
    rstn = 1'b1;
    ref_hi = '0;
    ref_lo = '0;
    repeat (MUL_LAT + 2) @(negedge clk);
    check("arst_hold_hi", bus.hi, 0);
    check("arst_hold_lo", bus.lo, 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
